post_normalise32: RTL and testbench

//  Iterative post-normaliser and packer for the single-precision add/sub datapath. Sits after the

---
 rtl/post_normalise32_pkg.sv | 20 ++
 rtl/post_normalise32_fp32_pack.sv | 26 ++
 rtl/post_normalise32.sv | 155 +++++++++++++++
 tb/tb_post_normalise32.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/post_normalise32_pkg.sv
// Shared constants and encodings for the single-precision add/sub post-normalise stage.
package post_normalise32_pkg;

    localparam int DEF_FRAC_W = 23;
    localparam int DEF_EXP_W  = 8;
    localparam int BIAS       = 127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PK_WORD = 2'd0,
        PK_INF  = 2'd1,
        PK_ZERO = 2'd2
    } pack_sel_t;

endpackage

// File: rtl/post_normalise32_fp32_pack.sv
// Combinational IEEE-754 packer: selects the normal word, signed infinity or signed zero.
module fp32_pack
    import post_normalise32_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic                    s,
    input  logic [EXP_W-1:0]        e,
    input  logic [FRAC_W-1:0]       f,
    input  pack_sel_t               sel,
    output logic [EXP_W+FRAC_W:0]   word
);

    // Word selection; anything unexpected collapses to signed zero.
    always_comb begin
        word = {(EXP_W+FRAC_W+1){1'b0}};
        case (sel)
            PK_WORD: word = {s, e, f};
            PK_INF:  word = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            PK_ZERO: word = {s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            default: word = {s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
        endcase
    end

endmodule

// File: rtl/post_normalise32.sv
// Iterative post-normaliser: shifts the raw sum one bit per enabled cycle, then packs the result
// with truncation and overflow/underflow flags.
module post_normalise32
    import post_normalise32_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic                    S,
    input  logic [FRAC_W+1:0]       M,
    input  logic [EXP_W-1:0]        E,
    output logic [EXP_W+FRAC_W:0]   R,
    output logic                    done,
    output logic                    OF,
    output logic                    UF
);

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [FRAC_W+1:0]        m_r;
    logic [EXP_W-1:0]         e_r;
    logic                     s_r;
    logic [EXP_W+FRAC_W:0]    r_r;
    logic                     done_r;
    logic                     of_r;
    logic                     uf_r;

    logic                     finish_s;
    logic                     of_s;
    logic                     uf_s;
    pack_sel_t                pack_sel_s;
    logic [EXP_W-1:0]         pack_e_s;
    logic [FRAC_W-1:0]        pack_f_s;
    logic [EXP_W-1:0]         e_inc_s;
    logic [EXP_W+FRAC_W:0]    pack_word_s;

    // One normalisation step: the check order keeps the exponent from ever wrapping.
    always_comb begin
        finish_s   = 1'b0;
        of_s       = 1'b0;
        uf_s       = 1'b0;
        pack_sel_s = PK_ZERO;
        pack_e_s   = e_r;
        pack_f_s   = {FRAC_W{1'b0}};
        e_inc_s    = e_r + EXP_ONE;
        if (e_r == EXP_MAX) begin
            finish_s   = 1'b1;
            of_s       = 1'b1;
            pack_sel_s = PK_INF;
        end else if (m_r == {(FRAC_W+2){1'b0}}) begin
            finish_s   = 1'b1;
            pack_sel_s = PK_ZERO;
        end else if (m_r[FRAC_W+1]) begin
            finish_s = 1'b1;
            if (e_inc_s == EXP_MAX) begin
                of_s       = 1'b1;
                pack_sel_s = PK_INF;
            end else begin
                pack_sel_s = PK_WORD;
                pack_e_s   = e_inc_s;
                pack_f_s   = m_r[FRAC_W:1];
            end
        end else if (m_r[FRAC_W]) begin
            finish_s   = 1'b1;
            pack_sel_s = PK_WORD;
            pack_f_s   = m_r[FRAC_W-1:0];
        end else if (e_r <= EXP_ONE) begin
            finish_s   = 1'b1;
            uf_s       = 1'b1;
            pack_sel_s = PK_ZERO;
        end else begin
            finish_s   = 1'b0;
        end
    end

    fp32_pack #(
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W)
    ) u_pack (
        .s    (s_r),
        .e    (pack_e_s),
        .f    (pack_f_s),
        .sel  (pack_sel_s),
        .word (pack_word_s)
    );

    // Next-state logic; load restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (load) begin
            state_nxt_s = ST_NORM;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_NORM: state_nxt_s = finish_s ? ST_DONE : ST_NORM;
                ST_DONE: state_nxt_s = ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register, advanced only on enabled edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (en) begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shift/exponent registers and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r    <= {(FRAC_W+2){1'b0}};
            e_r    <= {EXP_W{1'b0}};
            s_r    <= 1'b0;
            r_r    <= {(EXP_W+FRAC_W+1){1'b0}};
            done_r <= 1'b0;
            of_r   <= 1'b0;
            uf_r   <= 1'b0;
        end else if (en) begin
            if (load) begin
                m_r    <= M;
                e_r    <= E;
                s_r    <= S;
                done_r <= 1'b0;
                of_r   <= 1'b0;
                uf_r   <= 1'b0;
            end else if (state_r == ST_NORM) begin
                if (finish_s) begin
                    r_r    <= pack_word_s;
                    of_r   <= of_s;
                    uf_r   <= uf_s;
                    done_r <= 1'b1;
                end else begin
                    m_r <= m_r << 1;
                    e_r <= e_r - EXP_ONE;
                end
            end
        end
    end

    assign R    = r_r;
    assign done = done_r;
    assign OF   = of_r;
    assign UF   = uf_r;

endmodule

// File: tb/tb_post_normalise32.sv
// Directed and randomized checks of post_normalise32 against a closed-form reference model.
module tb_post_normalise32;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic        S;
    logic [24:0] M;
    logic [7:0]  E;
    logic [31:0] R;
    logic        done;
    logic        OF;
    logic        UF;

    int tests = 0;
    int fails = 0;

    post_normalise32 dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .S    (S),
        .M    (M),
        .E    (E),
        .R    (R),
        .done (done),
        .OF   (OF),
        .UF   (UF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result from the value rules: leading-one distance decides shift count and exponent.
    function automatic void ref_model(input logic s, input logic [24:0] m, input logic [7:0] e,
                                      output logic [31:0] r, output logic of, output logic uf,
                                      output int lat);
        int k;
        logic [24:0] mm;
        of = 1'b0; uf = 1'b0; lat = 1; r = 32'h0; k = 0; mm = m;
        if (e == 8'd255) begin
            r = {s, 8'hFF, 23'h0}; of = 1'b1;
        end else if (m == 25'd0) begin
            r = {s, 31'h0};
        end else if (m[24]) begin
            if (e == 8'd254) begin
                r = {s, 8'hFF, 23'h0}; of = 1'b1;
            end else begin
                r = {s, 8'(int'(e) + 1), m[23:1]};
            end
        end else begin
            while (mm[23] == 1'b0) begin
                mm = mm << 1;
                k++;
            end
            if (k == 0 || int'(e) - k >= 1) begin
                r = {s, 8'(int'(e) - k), mm[22:0]};
                lat = k + 1;
            end else begin
                r = {s, 31'h0}; uf = 1'b1;
                lat = (e >= 8'd1) ? int'(e) : 1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic s, input logic [24:0] m, input logic [7:0] e);
        en = 1'b1; load = 1'b1; S = s; M = m; E = e;
        step();
        load = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (lat < budget && done !== 1'b1) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [24:0] m, input logic [7:0] e);
        logic [31:0] exp_r;
        logic        exp_of;
        logic        exp_uf;
        int          exp_lat;
        int          lat;
        ref_model(s, m, e, exp_r, exp_of, exp_uf, exp_lat);
        do_load(s, m, e);
        check({tag, "_done_clr"}, {31'h0, done}, 32'h0);
        wait_done(40, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_R"}, R, exp_r);
        check({tag, "_OF"}, {31'h0, OF}, {31'h0, exp_of});
        check({tag, "_UF"}, {31'h0, UF}, {31'h0, exp_uf});
    endtask

    initial begin
        int lat;
        logic [31:0] r_hold;
        logic        rs;
        logic [24:0] rm;
        logic [7:0]  re;

        rst = 1'b1; en = 1'b1; load = 1'b0; S = 1'b0; M = 25'h0; E = 8'h0;
        step(); step();
        rst = 1'b0;
        check("rst_R", R, 32'h0);
        check("rst_flags", {29'h0, done, OF, UF}, 32'h0);

        run_op("one",      1'b0, 25'h0800000, 8'd127);
        check("one_const", R, 32'h3F800000);
        run_op("carry",    1'b0, 25'h1000000, 8'd127);
        check("carry_const", R, 32'h40000000);
        run_op("carry_of", 1'b1, 25'h1000000, 8'd254);
        check("carry_of_const", R, 32'hFF800000);
        run_op("emax",     1'b0, 25'h0800000, 8'd255);
        run_op("deep",     1'b0, 25'h0000001, 8'd127);
        check("deep_const", R, 32'h34000000);
        run_op("uf",       1'b0, 25'h0000100, 8'd3);
        run_op("zero",     1'b1, 25'h0000000, 8'd127);
        check("zero_const", R, 32'h80000000);

        // Hold in DONE, and load ignored while en=0.
        r_hold = R;
        step(); step(); step();
        check("hold_done", {31'h0, done}, 32'h1);
        check("hold_R", R, r_hold);
        en = 1'b0; load = 1'b1; M = 25'h0800000; E = 8'd127; S = 1'b0;
        step(); step();
        load = 1'b0;
        check("en0_done", {31'h0, done}, 32'h1);
        check("en0_R", R, r_hold);
        en = 1'b1;

        // Pause for 5 edges mid-normalisation.
        do_load(1'b0, 25'h0000001, 8'd127);
        step(); step(); step(); step(); step();
        en = 1'b0;
        step(); step(); step(); step(); step();
        check("pause_done", {31'h0, done}, 32'h0);
        check("pause_R", R, r_hold);
        en = 1'b1;
        wait_done(40, lat);
        check("pause_lat", 32'(lat + 10), 32'd29);
        check("pause_result", R, 32'h34000000);

        // New load discards an in-flight operation.
        do_load(1'b0, 25'h0000001, 8'd127);
        step(); step(); step();
        check("midload_busy", {31'h0, done}, 32'h0);
        run_op("midload", 1'b0, 25'h0800000, 8'd127);
        check("midload_const", R, 32'h3F800000);

        // Reset in the middle of an operation.
        do_load(1'b1, 25'h0000001, 8'd127);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_R", R, 32'h0);
        check("midrst_flags", {29'h0, done, OF, UF}, 32'h0);
        run_op("post_rst", 1'b0, 25'h0800000, 8'd127);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 25'($urandom) >> $urandom_range(0, 25);
            re = 8'($urandom);
            if ($urandom_range(0, 3) == 0) re = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) re = 8'($urandom_range(252, 255));
            run_op("rand", rs, rm, re);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
